mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Multi-cycle controller for the multiply-accumulate path: accepts a MUL/MLA request from decode and iterates the multiply STEP_W multiplier bits per cycle.
- Terminates early once the remaining multiplier bits are zero.
- Returns the 32-bit product or accumulation with NZCV flags via a start/busy/done handshake.
- Sits between instruction decode and register-file writeback; it is the block that sequences the shared multiplier datapath.

Parameters:
- DATA_W, 32, operand/result width.
- STEP_W, 8, multiplier bits consumed per MULT cycle; must divide DATA_W exactly.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; accepted only when ready=1
- accumulate  input  1  1 = MLA (Rm*Rs + Rn), 0 = MUL (Rm*Rs)
- rm  input  DATA_W  multiplicand
- rs  input  DATA_W  multiplier; iterated STEP_W bits per cycle, LSB first
- rn  input  DATA_W  accumulator operand; ignored when accumulate=0
- ready  output  1  high in IDLE only
- busy  output  1  high in MULT and DONE
- done  output  1  single-cycle pulse; result and nzcv valid while high
- result  output  DATA_W  low DATA_W bits of the product/sum; holds value until next done
- nzcv  output  4  {N, Z, C, V}; holds value until next done
- cycles  output  3  number of MULT cycles used by the last operation, for the pipeline-stall counter

Behaviour:
- States: IDLE, MULT, DONE. Reset value is IDLE.
- Reset values: ready=1, busy=0, done=0, result=0, nzcv=4'b0000, cycles=0.
- Reset has priority over all other inputs. Reset mid-operation aborts to IDLE, discards the partial product and clears the outputs to their reset values.
- IDLE, start=1 on a clock edge:
  - Latch rm into mcand and rs into mplier.
  - Load acc with rn if accumulate=1, else 0.
  - Clear the step counter k. Go to MULT.
- IDLE, start=0: remain in IDLE.
- MULT, each cycle:
  - acc <= acc + ((mcand * mplier[STEP_W-1:0]) << (STEP_W*k)), truncated modulo 2^DATA_W.
  - mplier <= mplier >> STEP_W (logical shift).
  - k <= k+1.
- MULT exit: go to DONE when the shifted mplier == 0, or when k reaches DATA_W/STEP_W - 1. Otherwise stay in MULT.
- Minimum of 1 MULT cycle, even when rs=0. Maximum of DATA_W/STEP_W cycles (4 at default parameters).
- DONE, one cycle:
  - done=1, result=acc, cycles=k+1 (the number of MULT cycles executed).
  - nzcv = {acc[DATA_W-1], acc==0, 1'b0, 1'b0}. C and V are always 0; there is no saturation.
  - Unconditionally return to IDLE on the next edge.
- Latency: done is asserted N+1 cycles after the start edge, where N is the number of MULT cycles.
- Signedness: the low DATA_W bits are identical for signed and unsigned operands. Operands are treated as bit vectors and no sign handling is done.
- start while busy=1 (including the DONE cycle) is ignored and produces no queued request. The earliest back-to-back start is accepted in the cycle after done.
- Operand inputs are sampled only on the accepting edge. Later changes to rm, rs or rn have no effect on an operation in flight.
- Intermediate arithmetic must be at least DATA_W+STEP_W bits wide before truncation; no overflow detection.

Test Plan:
- Reset asserted for 2 cycles -> ready=1, busy=0, done=0, result=0, nzcv=0000, cycles=0.
- MUL: rm=3, rs=5, accumulate=0 -> one MULT cycle; done on the 2nd edge after start; result=15, nzcv=0000, cycles=1.
- MUL with long multiplier: rm=2, rs=32'h0100_0000 -> 4 MULT cycles; result=32'h0200_0000, cycles=4. Also rm=32'h1234_5678, rs=0 -> cycles=1, result=0, nzcv=0100.
- MLA negative: rm=32'hFFFF_FFFF, rs=2, rn=5, accumulate=1 -> result=3, nzcv=0000. Then rm=32'hFFFF_FFFF, rs=7, rn=0, accumulate=1 -> result=32'hFFFF_FFF9, nzcv=1000.
- Handshake: start held high during MULT and DONE with different operands -> only the first request completes and exactly one done pulse is seen. A start in the cycle after done is accepted and completes correctly.
- Reset mid-operation: start rm=5, rs=32'hFF00_0000, assert reset during the 2nd MULT cycle -> next cycle is IDLE, no done pulse, result=0. A new request afterwards completes correctly.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: multi-cycle MUL/MLA controller. Consumes STEP_W multiplier
// bits per MULT cycle, LSB first, and stops early once the remaining
// multiplier bits are all zero. Result and NZCV are returned with a
// start/busy/done handshake.
module mac_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] rm,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rn,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzcv,
    output logic [2:0]        cycles
);

    localparam int unsigned STEPS  = DATA_W / STEP_W;
    localparam int unsigned PROD_W = DATA_W + STEP_W;
    localparam logic [2:0]  K_LAST = 3'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [2:0]        r_k;

    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_nzcv;
    logic [2:0]        r_cycles;

    logic [PROD_W-1:0] w_prod;
    logic [DATA_W-1:0] w_term;
    logic [DATA_W-1:0] w_acc_next;
    logic [DATA_W-1:0] w_mplier_shift;
    logic              w_mult_last;

    // Partial product kept DATA_W+STEP_W wide, then aligned to step k and truncated
    always_comb begin
        w_prod         = PROD_W'(r_mcand) * PROD_W'(r_mplier[STEP_W-1:0]);
        w_term         = DATA_W'(w_prod << (STEP_W * r_k));
        w_acc_next     = r_acc + w_term;
        w_mplier_shift = r_mplier >> STEP_W;
        w_mult_last    = (w_mplier_shift == '0) || (r_k == K_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_MULT;
            S_MULT:  if (w_mult_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture and shift-add iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_k      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= rm;
                        r_mplier <= rs;
                        r_acc    <= accumulate ? rn : '0;
                        r_k      <= '0;
                    end
                end
                S_MULT: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= w_mplier_shift;
                    r_k      <= 3'(r_k + 3'd1);
                end
                default: ;
            endcase
        end
    end

    // Registered handshake and result; result/nzcv/cycles load on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_nzcv   <= 4'b0000;
            r_cycles <= '0;
        end else begin
            r_ready <= (w_state_next == S_IDLE);
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (r_state == S_MULT) && w_mult_last;
            if ((r_state == S_MULT) && w_mult_last) begin
                r_result <= w_acc_next;
                r_nzcv   <= {w_acc_next[DATA_W-1], (w_acc_next == '0), 2'b00};
                r_cycles <= 3'(r_k + 3'd1);
            end
        end
    end

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign nzcv   = r_nzcv;
    assign cycles = r_cycles;

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: transaction-level model plus directed vectors.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        accumulate = 1'b0;
    logic [31:0] rm = '0;
    logic [31:0] rs = '0;
    logic [31:0] rn = '0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  nzcv;
    logic [2:0]  cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    mac_sequencer #(.DATA_W(32), .STEP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .rm         (rm),
        .rs         (rs),
        .rn         (rn),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .nzcv       (nzcv),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: an accepted request occupies the block for N+1 cycles, done on the last.
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_res   = '0;
    logic [3:0]  m_nzcv  = '0;
    logic [2:0]  m_cyc   = '0;
    logic [31:0] p_res   = '0;
    logic [2:0]  p_cyc   = '0;

    initial forever begin
        int n;
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_res   = '0;
            m_nzcv  = '0;
            m_cyc   = '0;
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 1) begin
                m_res  = p_res;
                m_nzcv = {p_res[31], (p_res == 32'd0), 2'b00};
                m_cyc  = p_cyc;
            end
        end else if (start) begin
            n = 1;
            while (n < 4 && (rs >> (8 * n)) != 32'd0) n++;
            p_cyc  = 3'(n);
            p_res  = 32'(({32'd0, rm} * {32'd0, rs}) + (accumulate ? {32'd0, rn} : 64'd0));
            m_left = n + 1;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (done === 1'b1) n_done++;
        if (m_valid) begin
            check("cyc ready",  32'(ready),  32'(m_left == 0));
            check("cyc busy",   32'(busy),   32'(m_left != 0));
            check("cyc done",   32'(done),   32'(m_left == 1));
            check("cyc result", result,      m_res);
            check("cyc nzcv",   32'(nzcv),   32'(m_nzcv));
            check("cyc cycles", 32'(cycles), 32'(m_cyc));
        end
    end

    // One request; operands are scrambled after acceptance to prove they are not re-sampled
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic acc, input logic [31:0] e_res,
                         input logic [3:0] e_nzcv, input logic [2:0] e_cyc);
        bit got;
        int lat;
        @(negedge clk);
        rm = a; rs = b; rn = c; accumulate = acc; start = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                rm = ~a; rs = ~b; rn = ~c; accumulate = ~acc;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done within 10 cycles", name);
        end else begin
            check({name, " result"},  result,       e_res);
            check({name, " nzcv"},    32'(nzcv),    32'(e_nzcv));
            check({name, " cycles"},  32'(cycles),  32'(e_cyc));
            check({name, " latency"}, 32'(lat),     32'(e_cyc) + 32'd1);
        end
    endtask

    initial begin
        bit got;
        int lat;
        int d0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready",  32'(ready),  32'd1);
        check("rst busy",   32'(busy),   32'd0);
        check("rst done",   32'(done),   32'd0);
        check("rst result", result,      32'd0);
        check("rst nzcv",   32'(nzcv),   32'd0);
        check("rst cycles", 32'(cycles), 32'd0);
        reset = 1'b0;

        do_op("mul3x5",   32'd3,           32'd5,           32'd100,         1'b0, 32'd15,          4'b0000, 3'd1);
        do_op("mul_long", 32'd2,           32'h0100_0000,   32'd0,           1'b0, 32'h0200_0000,   4'b0000, 3'd4);
        do_op("mul_zero", 32'h1234_5678,   32'd0,           32'd0,           1'b0, 32'd0,           4'b0100, 3'd1);
        do_op("mla_neg",  32'hFFFF_FFFF,   32'd2,           32'd5,           1'b1, 32'd3,           4'b0000, 3'd1);
        do_op("mla_n",    32'hFFFF_FFFF,   32'd7,           32'd0,           1'b1, 32'hFFFF_FFF9,   4'b1000, 3'd1);
        do_op("mla_3cyc", 32'h10,          32'h0001_0203,   32'h1000_0000,   1'b1, 32'h1010_2030,   4'b0000, 3'd3);

        // start held through MULT and DONE with changing operands
        repeat (2) @(negedge clk);
        d0 = n_done;
        rm = 32'd2; rs = 32'h0100_0000; rn = 32'd0; accumulate = 1'b0; start = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            rm = 32'h77; rs = 32'h3; rn = 32'h1; accumulate = 1'b1;
            if (done === 1'b1) begin
                got   = 1'b1;
                lat   = i;
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL hold timeout: no done within 10 cycles");
        end else begin
            check("hold result",  result,   32'h0200_0000);
            check("hold latency", 32'(lat), 32'd5);
        end
        // earliest back-to-back request, in the cycle after done
        do_op("b2b", 32'd9, 32'd11, 32'd1, 1'b1, 32'd100, 4'b0000, 3'd1);
        repeat (4) @(negedge clk);
        check("hold done count", 32'(n_done - d0), 32'd2);

        // reset during the second MULT cycle
        @(negedge clk);
        d0 = n_done;
        rm = 32'd5; rs = 32'hFF00_0000; rn = 32'd0; accumulate = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst ready",  32'(ready), 32'd1);
        check("midrst busy",   32'(busy),  32'd0);
        check("midrst result", result,     32'd0);
        repeat (6) @(negedge clk);
        check("midrst no done", 32'(n_done - d0), 32'd0);
        do_op("after_rst", 32'd5, 32'hFF00_0000, 32'd0, 1'b0, 32'hFB00_0000, 4'b1000, 3'd4);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
